// File: rtl/haar_dwt_pkg.sv
// Shared types and helpers for the multi-level Haar DWT stream engine.
// Holds the FSM encoding, default scaling constants and the saturation/level-clamp functions.
package haar_dwt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam int COEF_Q8        = 181;
   localparam int FRAC_BITS      = 8;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_N          = 8;
   localparam int DEF_MAX_LEVELS = 3;

   // Working width for saturation; comfortably wider than any product-sum used here.
   localparam int SAT_W = 48;

   function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                         input int w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
      lo = -hi - SAT_W'(1);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int clamp_levels(input int req, input int max_l);
      if (req == 0) return 1;
      if (req > max_l) return max_l;
      return req;
   endfunction

endpackage

// File: rtl/haar_dwt_multilevel_stream_core.sv
// Combinational Haar butterfly: scales a pair by 1/sqrt(2) in fixed point,
// floors the sum/difference and saturates both to the coefficient width.
module haar_pair_sat_core
   import haar_dwt_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF   = COEF_Q8,
   parameter int FRAC   = FRAC_BITS
) (
   input  logic signed [DATA_W-1:0] i_x0,
   input  logic signed [DATA_W-1:0] i_x1,
   output logic signed [DATA_W-1:0] o_ca,
   output logic signed [DATA_W-1:0] o_cd,
   output logic                     o_sat
);

   localparam int PW = DATA_W + 10;
   localparam logic signed [PW-1:0] C = PW'(COEF);

   logic signed [PW-1:0]    w_p0, w_p1, w_s, w_d, w_s_sh, w_d_sh;
   logic signed [SAT_W-1:0] w_s_wide, w_d_wide, w_s_cl, w_d_cl;

   assign w_p0   = PW'(i_x0) * C;
   assign w_p1   = PW'(i_x1) * C;
   assign w_s    = w_p0 + w_p1;
   assign w_d    = w_p0 - w_p1;
   assign w_s_sh = w_s >>> FRAC;
   assign w_d_sh = w_d >>> FRAC;

   assign w_s_wide = SAT_W'(w_s_sh);
   assign w_d_wide = SAT_W'(w_d_sh);
   assign w_s_cl   = sat_clamp(w_s_wide, DATA_W);
   assign w_d_cl   = sat_clamp(w_d_wide, DATA_W);

   assign o_ca  = w_s_cl[DATA_W-1:0];
   assign o_cd  = w_d_cl[DATA_W-1:0];
   assign o_sat = (w_s_cl != w_s_wide) || (w_d_cl != w_d_wide);

endmodule

// File: rtl/haar_dwt_multilevel_stream.sv
// Streaming multi-level 1-D Haar DWT: buffers a frame, decomposes it in place
// one pair per cycle, then streams coefficients out in Mallat order.
//
// state   | meaning
// IDLE    | post-reset, moves to LOAD next cycle
// LOAD    | accepting N input samples (in_ready=1)
// COMPUTE | one butterfly per cycle over levels 1..L
// DRAIN   | streaming N coefficients with backpressure
module haar_dwt_multilevel_stream
   import haar_dwt_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int N          = DEF_N,
   parameter int MAX_LEVELS = DEF_MAX_LEVELS,
   parameter int COEF       = COEF_Q8,
   parameter int FRAC       = FRAC_BITS
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [$clog2(MAX_LEVELS):0]   cfg_levels,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [DATA_W-1:0]      in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_W-1:0]      out_data,
   output logic                          out_detail,
   output logic                          out_last,
   output logic                          busy,
   output logic                          sat_flag
);

   localparam int CFG_W = $clog2(MAX_LEVELS) + 1;
   localparam int IDX_W = $clog2(N);

   state_t r_state, w_state_nxt;

   logic [IDX_W-1:0] r_wr_idx, r_k;
   logic [IDX_W:0]   r_len, r_out_idx;
   logic [CFG_W-1:0] r_levels, r_lvl;

   logic signed [DATA_W-1:0] r_buf [N];
   logic signed [DATA_W-1:0] r_det [N];

   logic                     r_out_valid, r_out_detail, r_out_last, r_sat;
   logic signed [DATA_W-1:0] r_out_data;

   logic                     w_in_fire, w_pair_last, w_lvl_last, w_compute_done;
   logic                     w_out_hs, w_drain_done, w_load_beat, w_is_det, w_sat;
   logic [IDX_W-1:0]         w_half, w_i0, w_i1, w_det_idx, w_rd_idx;
   logic [IDX_W:0]           w_n_appr;
   logic [CFG_W-1:0]         w_cfg_cl;
   logic signed [DATA_W-1:0] w_ca, w_cd;

   assign w_in_fire      = in_valid && (r_state == LOAD);
   assign w_half         = r_len[IDX_W:1];
   assign w_pair_last    = (r_k == w_half - IDX_W'(1));
   assign w_lvl_last     = (r_lvl == r_levels);
   assign w_compute_done = (r_state == COMPUTE) && w_pair_last && w_lvl_last;
   // Reads at 2k/2k+1 never trail the write at k, so the in-place update is safe.
   assign w_i0           = IDX_W'({r_k, 1'b0});
   assign w_i1           = w_i0 | IDX_W'(1);
   assign w_det_idx      = w_half + r_k;
   assign w_cfg_cl       = CFG_W'(clamp_levels(int'(cfg_levels), MAX_LEVELS));

   assign w_out_hs     = r_out_valid && out_ready;
   assign w_drain_done = (r_state == DRAIN) && w_out_hs && r_out_last;
   assign w_load_beat  = (r_state == DRAIN) && (!r_out_valid || out_ready)
                         && (r_out_idx < (IDX_W+1)'(N));
   assign w_rd_idx     = r_out_idx[IDX_W-1:0];
   assign w_n_appr     = (IDX_W+1)'(N) >> r_levels;
   assign w_is_det     = (r_out_idx >= w_n_appr);

   haar_pair_sat_core #(
      .DATA_W (DATA_W),
      .COEF   (COEF),
      .FRAC   (FRAC)
   ) u_core (
      .i_x0  (r_buf[w_i0]),
      .i_x1  (r_buf[w_i1]),
      .o_ca  (w_ca),
      .o_cd  (w_cd),
      .o_sat (w_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE:    w_state_nxt = LOAD;
         LOAD: begin
            in_ready = 1'b1;
            if (w_in_fire && (r_wr_idx == IDX_W'(N - 1))) w_state_nxt = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (w_compute_done) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (w_drain_done) w_state_nxt = LOAD;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx     <= '0;
         r_k          <= '0;
         r_len        <= '0;
         r_lvl        <= '0;
         r_levels     <= '0;
         r_out_idx    <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_detail <= 1'b0;
         r_out_last   <= 1'b0;
         r_sat        <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_in_fire) begin
                  r_wr_idx <= r_wr_idx + IDX_W'(1);
                  if (r_wr_idx == '0) begin
                     r_levels <= w_cfg_cl;
                     r_sat    <= 1'b0;
                  end
                  r_k   <= '0;
                  r_lvl <= CFG_W'(1);
                  r_len <= (IDX_W+1)'(N);
               end
            end
            COMPUTE: begin
               r_sat <= r_sat | w_sat;
               if (w_pair_last) begin
                  r_k <= '0;
                  if (w_lvl_last) begin
                     r_out_idx <= '0;
                  end else begin
                     r_lvl <= r_lvl + CFG_W'(1);
                     r_len <= r_len >> 1;
                  end
               end else begin
                  r_k <= r_k + IDX_W'(1);
               end
            end
            DRAIN: begin
               if (w_load_beat) begin
                  r_out_valid  <= 1'b1;
                  r_out_data   <= w_is_det ? r_det[w_rd_idx] : r_buf[w_rd_idx];
                  r_out_detail <= w_is_det;
                  r_out_last   <= (r_out_idx == (IDX_W+1)'(N - 1));
                  r_out_idx    <= r_out_idx + (IDX_W+1)'(1);
               end else if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_buf[r_wr_idx] <= in_data;
      end else if (r_state == COMPUTE) begin
         r_buf[r_k]       <= w_ca;
         r_det[w_det_idx] <= w_cd;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_detail = r_out_detail;
   assign out_last   = r_out_last;
   assign sat_flag   = r_sat;

endmodule

// File: tb/tb_haar_dwt_multilevel_stream.sv
// Directed self-checking bench for the multi-level Haar DWT stream engine (N=8, DATA_W=16).
module tb_haar_dwt_multilevel_stream;

   logic               clk;
   logic               rst_n;
   logic [2:0]         cfg_levels;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic               out_detail;
   logic               out_last;
   logic               busy;
   logic               sat_flag;

   int n_cmp  = 0;
   int n_fail = 0;

   logic signed [15:0] fr [8];
   logic signed [15:0] ex [8];
   logic [5:0]         bp_pat = 6'b101001;

   haar_dwt_multilevel_stream dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_levels (cfg_levels),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_detail (out_detail),
      .out_last   (out_last),
      .busy       (busy),
      .sat_flag   (sat_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic send_frame(input logic [2:0] c0, input logic [2:0] c1, input bit chk_clr);
      int t;
      for (int i = 0; i < 8; i++) begin
         cfg_levels = (i == 0) ? c0 : c1;
         in_data    = fr[3'(i)];
         in_valid   = 1'b1;
         t = 0;
         while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL in_ready_timeout beat %0d: in_ready=%b, required 1", i, in_ready);
            break;
         end
         @(negedge clk);
         if (chk_clr && i == 0) begin
            n_cmp++;
            if (sat_flag !== 1'b0) begin
               n_fail++;
               $display("FAIL sat_clear_first_beat: sat_flag=%b, required 0", sat_flag);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic recv_frame(input int napprox, input bit use_bp, input bit exp_sat, output int pre);
      int got, cyc;
      bit stalled, rdy_bad;
      logic signed [15:0] held;
      logic [2:0] ph;
      got = 0; cyc = 0; stalled = 0; rdy_bad = 0; pre = 0; held = '0;
      while (got < 8 && cyc < 400) begin
         if (stalled) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               n_fail++;
               $display("FAIL stall_hold beat %0d: valid=%b data=%0d, required valid=1 data=%0d",
                        got, out_valid, out_data, held);
            end
         end
         stalled = 0;
         if (in_ready !== 1'b0) rdy_bad = 1;
         if (got == 0 && out_valid !== 1'b1 && busy === 1'b1) pre++;
         ph = 3'(cyc % 6);
         out_ready = use_bp ? bp_pat[ph] : 1'b1;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               n_cmp++;
               if (out_data !== ex[3'(got)]) begin
                  n_fail++;
                  $display("FAIL out_data beat %0d: got %0d, required %0d", got, out_data, ex[3'(got)]);
               end
               n_cmp++;
               if (out_detail !== logic'(got >= napprox)) begin
                  n_fail++;
                  $display("FAIL out_detail beat %0d: got %b, required %b", got, out_detail, got >= napprox);
               end
               n_cmp++;
               if (out_last !== logic'(got == 7)) begin
                  n_fail++;
                  $display("FAIL out_last beat %0d: got %b, required %b", got, out_last, got == 7);
               end
               got++;
            end else begin
               stalled = 1;
               held    = out_data;
            end
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      n_cmp++;
      if (got != 8) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d beats, required 8", got);
      end
      n_cmp++;
      if (rdy_bad) begin
         n_fail++;
         $display("FAIL in_ready_during_frame: seen 1, required 0 until last handshake");
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL in_ready_after_drain: got %b, required 1", in_ready);
      end
      n_cmp++;
      if (sat_flag !== exp_sat) begin
         n_fail++;
         $display("FAIL sat_flag: got %b, required %b", sat_flag, exp_sat);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cfg_levels = 3'd1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      n_cmp++;
      if ({in_ready, out_valid, out_detail, out_last, busy, sat_flag} !== 6'b0 || out_data !== 16'sd0) begin
         n_fail++;
         $display("FAIL reset_values: rdy=%b vld=%b det=%b last=%b busy=%b sat=%b data=%0d, required all 0",
                  in_ready, out_valid, out_detail, out_last, busy, sat_flag, out_data);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_to_load: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_single_level;
      int pre;
      fr = '{16'sd256, 16'sd0, 16'sd0, 16'sd256, 16'sd100, 16'sd100, 16'sd0, 16'sd0};
      ex = '{16'sd181, 16'sd181, 16'sd141, 16'sd0, 16'sd181, -16'sd181, 16'sd0, 16'sd0};
      send_frame(3'd1, 3'd1, 1'b0);
      recv_frame(4, 1'b0, 1'b0, pre);
      n_cmp++;
      if (pre != 5) begin
         n_fail++;
         $display("FAIL single_latency: %0d cycles before first beat, required 5", pre);
      end
   endtask

   task automatic test_three_level;
      int pre;
      fr = '{default: 16'sd100};
      ex = '{16'sd281, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      send_frame(3'd3, 3'd3, 1'b0);
      recv_frame(1, 1'b0, 1'b0, pre);
      n_cmp++;
      if (pre != 8) begin
         n_fail++;
         $display("FAIL three_level_latency: %0d cycles before first beat, required 8", pre);
      end
   endtask

   task automatic test_saturation;
      int pre;
      fr = '{default: 16'sd32767};
      ex = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      send_frame(3'd1, 3'd1, 1'b0);
      recv_frame(4, 1'b0, 1'b1, pre);
      fr = '{default: 16'sd0};
      ex = '{default: 16'sd0};
      send_frame(3'd1, 3'd1, 1'b1);
      recv_frame(4, 1'b0, 1'b0, pre);
   endtask

   task automatic test_backpressure_back_to_back;
      int pre;
      fr = '{16'sd256, 16'sd0, 16'sd0, 16'sd256, 16'sd100, 16'sd100, 16'sd0, 16'sd0};
      ex = '{16'sd181, 16'sd181, 16'sd141, 16'sd0, 16'sd181, -16'sd181, 16'sd0, 16'sd0};
      for (int f = 0; f < 2; f++) begin
         send_frame(3'd1, 3'd1, 1'b0);
         recv_frame(4, 1'b1, 1'b0, pre);
      end
   endtask

   task automatic test_clamp;
      int pre;
      fr = '{-16'sd1, 16'sd0, -16'sd3, 16'sd5, 16'sd1000, -16'sd1000, 16'h8000, 16'h8000};
      ex = '{-16'sd1, 16'sd1, 16'sd0, 16'h8000, -16'sd1, -16'sd6, 16'sd1414, 16'sd0};
      send_frame(3'd0, 3'd0, 1'b0);
      recv_frame(4, 1'b0, 1'b1, pre);
      fr = '{default: 16'sd100};
      ex = '{16'sd281, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      send_frame(3'd7, 3'd7, 1'b1);
      recv_frame(1, 1'b0, 1'b0, pre);
   endtask

   task automatic test_cfg_sample;
      int pre;
      fr = '{default: 16'sd100};
      ex = '{16'sd141, 16'sd141, 16'sd141, 16'sd141, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      send_frame(3'd1, 3'd3, 1'b0);
      recv_frame(4, 1'b0, 1'b0, pre);
   endtask

   task automatic test_reset_mid;
      int pre, hs, t;
      fr = '{default: 16'sd100};
      send_frame(3'd3, 3'd3, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_compute: busy=%b rdy=%b vld=%b, required 0", busy, in_ready, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      fr = '{-16'sd1, 16'sd0, -16'sd3, 16'sd5, 16'sd1000, -16'sd1000, 16'h8000, 16'h8000};
      send_frame(3'd1, 3'd1, 1'b0);
      hs = 0; t = 0;
      while (hs < 3 && t < 100) begin
         out_ready = 1'b1;
         if (out_valid === 1'b1) hs++;
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (hs != 3 || out_data !== 16'h8000 || sat_flag !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_drain: hs=%0d data=%0d sat=%b, required 3 -32768 1", hs, out_data, sat_flag);
      end
      rst_n = 1'b0;
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, out_detail, out_last, busy, sat_flag} !== 6'b0 || out_data !== 16'sd0) begin
         n_fail++;
         $display("FAIL reset_in_drain: rdy=%b vld=%b det=%b last=%b busy=%b sat=%b data=%0d, required all 0",
                  in_ready, out_valid, out_detail, out_last, busy, sat_flag, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      fr = '{16'sd256, 16'sd0, 16'sd0, 16'sd256, 16'sd100, 16'sd100, 16'sd0, 16'sd0};
      ex = '{16'sd181, 16'sd181, 16'sd141, 16'sd0, 16'sd181, -16'sd181, 16'sd0, 16'sd0};
      send_frame(3'd1, 3'd1, 1'b0);
      recv_frame(4, 1'b0, 1'b0, pre);
   endtask

   initial begin
      test_reset();
      test_single_level();
      test_three_level();
      test_saturation();
      test_backpressure_back_to_back();
      test_clamp();
      test_cfg_sample();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
